// File: rtl/eaglesong_pkg.sv
// Shared definitions for the Eaglesong sponge controller.
// Holds the algorithm constants, the word/state types, the controller FSM
// encoding and a helper that packs the rate part of the state into a digest.
package eaglesong_pkg;

    localparam int          STATE_WORDS = 16;
    localparam int          RATE_WORDS  = 8;
    localparam logic [7:0]  DELIMITER   = 8'h06;
    localparam int          DIGEST_BITS = RATE_WORDS * 32;
    localparam logic [2:0]  LAST_IDX    = 3'(RATE_WORDS - 1);

    typedef logic [31:0] word_t;
    typedef word_t [STATE_WORDS-1:0] state_t;

    typedef enum logic [2:0] {
        ABSORB    = 3'd0,
        PAD       = 3'd1,
        PERM_REQ  = 3'd2,
        PERM_WAIT = 3'd3,
        DONE      = 3'd4
    } fsm_t;

    // Word 0 of the state lands in the most significant 32 bits.
    function automatic logic [DIGEST_BITS-1:0] rate_to_digest(input state_t s);
        logic [DIGEST_BITS-1:0] d;
        d = {DIGEST_BITS{1'b0}};
        for (int i = 0; i < RATE_WORDS; i++) begin
            d[DIGEST_BITS-1-32*i -: 32] = s[i];
        end
        return d;
    endfunction

endpackage

// File: rtl/eaglesong_pad_word.sv
// Masks the trailing bytes of a message word and inserts the padding
// delimiter right after the last valid byte.
// Ports:
//   data     - message word, first byte in [31:24]
//   bytes    - valid bytes in a last word (values above 4 behave as 4)
//   last     - word is the final word of the message
//   word     - word to XOR into the state
//   pad_done - delimiter was inserted into this word
module eaglesong_pad_word
    import eaglesong_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  bytes,
    input  logic        last,
    output logic [31:0] word,
    output logic        pad_done
);

    logic [2:0] n_s;

    // Byte-wise keep / delimiter / zero selection for a partial last word.
    always_comb begin
        n_s      = (bytes > 3'd4) ? 3'd4 : bytes;
        word     = 32'd0;
        pad_done = 1'b0;
        if (last && (n_s != 3'd4)) begin
            pad_done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < n_s) begin
                    word[31-8*i -: 8] = data[31-8*i -: 8];
                end else if (3'(i) == n_s) begin
                    word[31-8*i -: 8] = DELIMITER;
                end else begin
                    word[31-8*i -: 8] = 8'd0;
                end
            end
        end else begin
            // Full word: the delimiter goes into a later word.
            word = data;
        end
    end

endmodule

// File: rtl/eaglesong_sponge_ctrl.sv
// Initiator-side sponge controller for the Eaglesong permutation.
// Absorbs a byte-granular message (32-bit words) into the rate part of a
// 16x32-bit state, pads it, runs one permutation per 256-bit block through
// a start/done handshake and presents the 256-bit digest.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   msg_valid/ready/data/last/bytes - message word stream
//   perm_start, perm_state_out   - permutation request and input state
//   perm_done, perm_state_in     - permutation completion and result
//   digest_valid/ready, digest   - digest output handshake
module eaglesong_sponge_ctrl
    import eaglesong_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [31:0]            msg_data,
    input  logic                   msg_last,
    input  logic [2:0]             msg_bytes,
    output logic                   perm_start,
    output state_t                 perm_state_out,
    input  logic                   perm_done,
    input  state_t                 perm_state_in,
    output logic                   digest_valid,
    input  logic                   digest_ready,
    output logic [DIGEST_BITS-1:0] digest
);

    fsm_t                   fsm_r;
    state_t                 state_r;
    logic [2:0]             word_idx_r;
    logic                   pad_done_r;
    logic                   final_r;
    logic                   msg_ready_r;
    logic                   perm_start_r;
    logic                   digest_valid_r;
    logic [DIGEST_BITS-1:0] digest_r;

    logic [31:0]            pad_word_s;
    logic                   pad_flag_s;

    eaglesong_pad_word u_pad_word (
        .data     (msg_data),
        .bytes    (msg_bytes),
        .last     (msg_last),
        .word     (pad_word_s),
        .pad_done (pad_flag_s)
    );

    // Controller FSM: absorb, pad, permutation handshake and digest hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r          <= ABSORB;
            state_r        <= {(STATE_WORDS*32){1'b0}};
            word_idx_r     <= 3'd0;
            pad_done_r     <= 1'b0;
            final_r        <= 1'b0;
            msg_ready_r    <= 1'b0;
            perm_start_r   <= 1'b0;
            digest_valid_r <= 1'b0;
            digest_r       <= {DIGEST_BITS{1'b0}};
        end else begin
            case (fsm_r)
                ABSORB: begin
                    msg_ready_r <= 1'b1;
                    if (msg_valid && msg_ready_r) begin
                        state_r[word_idx_r] <= state_r[word_idx_r] ^ pad_word_s;
                        word_idx_r          <= word_idx_r + 3'd1;
                        if (msg_last) begin
                            final_r    <= 1'b1;
                            pad_done_r <= pad_flag_s;
                        end else begin
                            final_r    <= final_r;
                        end
                        if (word_idx_r == LAST_IDX) begin
                            // Block full: permute now; a pending delimiter
                            // then goes into word 0 of a fresh block.
                            fsm_r        <= PERM_REQ;
                            msg_ready_r  <= 1'b0;
                            perm_start_r <= 1'b1;
                        end else if (msg_last) begin
                            fsm_r       <= PAD;
                            msg_ready_r <= 1'b0;
                        end else begin
                            fsm_r <= ABSORB;
                        end
                    end else begin
                        fsm_r <= ABSORB;
                    end
                end
                PAD: begin
                    if (!pad_done_r) begin
                        state_r[word_idx_r] <= state_r[word_idx_r] ^ {DELIMITER, 24'h000000};
                        pad_done_r          <= 1'b1;
                    end else begin
                        pad_done_r <= pad_done_r;
                    end
                    fsm_r        <= PERM_REQ;
                    perm_start_r <= 1'b1;
                end
                PERM_REQ: begin
                    perm_start_r <= 1'b0;
                    fsm_r        <= PERM_WAIT;
                end
                PERM_WAIT: begin
                    if (perm_done) begin
                        state_r    <= perm_state_in;
                        word_idx_r <= 3'd0;
                        if (final_r && pad_done_r) begin
                            fsm_r          <= DONE;
                            digest_valid_r <= 1'b1;
                            digest_r       <= rate_to_digest(perm_state_in);
                        end else if (final_r) begin
                            fsm_r <= PAD;
                        end else begin
                            fsm_r       <= ABSORB;
                            msg_ready_r <= 1'b1;
                        end
                    end else begin
                        fsm_r <= PERM_WAIT;
                    end
                end
                DONE: begin
                    if (digest_ready) begin
                        state_r        <= {(STATE_WORDS*32){1'b0}};
                        pad_done_r     <= 1'b0;
                        final_r        <= 1'b0;
                        digest_valid_r <= 1'b0;
                        msg_ready_r    <= 1'b1;
                        fsm_r          <= ABSORB;
                    end else begin
                        fsm_r <= DONE;
                    end
                end
                default: begin
                    fsm_r          <= ABSORB;
                    msg_ready_r    <= 1'b0;
                    perm_start_r   <= 1'b0;
                    digest_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign msg_ready      = msg_ready_r;
    assign perm_start     = perm_start_r;
    assign perm_state_out = state_r;
    assign digest_valid   = digest_valid_r;
    assign digest         = digest_r;

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// Directed self-checking bench for eaglesong_sponge_ctrl with an identity
// permutation stub of programmable latency.
module tb_eaglesong_sponge_ctrl;
    import eaglesong_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [31:0]  msg_data = 32'd0;
    logic         msg_last = 1'b0;
    logic [2:0]   msg_bytes = 3'd0;
    logic         perm_start;
    state_t       perm_state_out;
    logic         perm_done = 1'b0;
    state_t       perm_state_in = {(STATE_WORDS*32){1'b0}};
    logic         digest_valid;
    logic         digest_ready = 1'b0;
    logic [255:0] digest;

    int checks = 0;
    int failures = 0;
    int stub_lat = 3;
    int stub_cnt = 0;
    int start_count = 0;
    logic perm_busy = 1'b0;
    int ready_viol = 0;

    eaglesong_sponge_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_data       (msg_data),
        .msg_last       (msg_last),
        .msg_bytes      (msg_bytes),
        .perm_start     (perm_start),
        .perm_state_out (perm_state_out),
        .perm_done      (perm_done),
        .perm_state_in  (perm_state_in),
        .digest_valid   (digest_valid),
        .digest_ready   (digest_ready),
        .digest         (digest)
    );

    always #5 clk = ~clk;

    // Identity permutation stub; deliberately ignores rst_n so a stale done can occur.
    always @(posedge clk) begin
        perm_done <= 1'b0;
        if (perm_start) begin
            stub_cnt      <= stub_lat;
            start_count   <= start_count + 1;
            perm_state_in <= perm_state_out;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) perm_done <= 1'b1;
        end
    end

    // Counts cycles where msg_ready is high while a permutation is outstanding.
    always @(negedge clk) begin
        if (perm_start) perm_busy <= 1'b1;
        else if (perm_done) perm_busy <= 1'b0;
        if ((perm_busy || perm_start) && msg_ready) ready_viol <= ready_viol + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one word (from a negedge) and returns at the negedge after acceptance.
    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
        int n;
        n = 0;
        msg_valid = 1'b1; msg_data = d; msg_last = l; msg_bytes = b;
        while (msg_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", {255'd0, (n < 400)}, 256'd1);
        @(negedge clk);
    endtask

    task automatic wait_digest(input string tag, input logic [255:0] exp);
        int n;
        n = 0;
        msg_valid = 1'b0;
        while (digest_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {255'd0, digest_valid}, 256'd1);
        chk(tag, digest, exp);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
    endtask

    initial begin
        int s0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_msg_ready", {255'd0, msg_ready}, 256'd0);
        chk("rst_perm_start", {255'd0, perm_start}, 256'd0);
        chk("rst_digest_valid", {255'd0, digest_valid}, 256'd0);
        chk("rst_digest", digest, 256'd0);
        chk("rst_state", perm_state_out[7:0], 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {255'd0, msg_ready}, 256'd1);

        // Empty message
        s0 = start_count;
        send_word(32'hdeadbeef, 1'b1, 3'd0);
        wait_digest("empty", {32'h06000000, 224'd0});
        chk("empty_starts", 256'(start_count - s0), 256'd1);

        // "abc"
        s0 = start_count;
        send_word(32'h61626300, 1'b1, 3'd3);
        wait_digest("abc", {32'h61626306, 224'd0});
        chk("abc_starts", 256'(start_count - s0), 256'd1);

        // Partial word masking
        send_word(32'hffffffff, 1'b1, 3'd1);
        wait_digest("mask1", {32'hff060000, 224'd0});

        // msg_bytes > 4 behaves as 4: delimiter goes to word 1
        send_word(32'h61626364, 1'b1, 3'd7);
        wait_digest("bytes7", {32'h61626364, 32'h06000000, 192'd0});

        // Eight full words, last full at index 7 -> two permutations
        s0 = start_count;
        for (int i = 1; i <= 8; i++) send_word(32'(i), (i == 8), 3'd4);
        wait_digest("eight", {32'h06000001, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
        chk("eight_starts", 256'(start_count - s0), 256'd2);

        // Backpressure: slow permutation, msg_valid held high across all words
        stub_lat = 10;
        s0 = ready_viol;
        for (int i = 1; i <= 10; i++) send_word(32'(i), (i == 10), 3'd4);
        wait_digest("bp", {32'd8, 32'd8, 32'h06000003, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
        chk("bp_ready_low", 256'(ready_viol - s0), 256'd0);

        // Reset during PERM_WAIT followed by a stale perm_done
        for (int i = 1; i <= 8; i++) send_word(32'(i), 1'b0, 3'd4);
        msg_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_count;
        repeat (15) @(negedge clk);
        chk("stale_state", perm_state_out[7:0], 256'd0);
        chk("stale_state_hi", perm_state_out[15:8], 256'd0);
        chk("stale_no_digest", {255'd0, digest_valid}, 256'd0);
        chk("stale_no_start", 256'(start_count - s0), 256'd0);
        chk("stale_ready", {255'd0, msg_ready}, 256'd1);
        stub_lat = 3;
        send_word(32'h00000000, 1'b1, 3'd0);
        wait_digest("after_rst", {32'h06000000, 224'd0});

        // digest_ready held low for 5 cycles
        send_word(32'h61626300, 1'b1, 3'd3);
        msg_valid = 1'b0;
        while (digest_valid !== 1'b1 && s0 < 400) begin
            @(negedge clk);
            s0++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", {255'd0, digest_valid}, 256'd1);
            chk("hold_digest", digest, {32'h61626306, 224'd0});
            chk("hold_ready", {255'd0, msg_ready}, 256'd0);
            @(negedge clk);
        end
        // Handshake together with a new word: word must wait one cycle
        digest_ready = 1'b1;
        msg_valid = 1'b1; msg_data = 32'h61000000; msg_last = 1'b1; msg_bytes = 3'd1;
        @(negedge clk);
        digest_ready = 1'b0;
        chk("hs_valid_low", {255'd0, digest_valid}, 256'd0);
        chk("hs_ready_high", {255'd0, msg_ready}, 256'd1);
        @(negedge clk);
        chk("hs_accepted", {255'd0, msg_ready}, 256'd0);
        wait_digest("hs_next", {32'h61060000, 224'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
